// File: rtl/dsp_fb_pkg.sv
// Shared widths, bunch-index sizing and the output slice/saturate helper
// for the multi-bunch charge-weighted feedback MAC.
package dsp_fb_pkg;

    localparam int CHARGE_W_DEF   = 21;
    localparam int SIGNAL_W_DEF   = 15;
    localparam int ACC_W_DEF      = 48;
    localparam int OUT_W_DEF      = 13;
    localparam int OUT_LSB_DEF    = 12;
    localparam int N_BUNCH_DEF    = 4;
    localparam int WINDOW_DEF     = 14;
    localparam int CAPTURE_AT_DEF = 1;
    localparam int CNT_W_DEF      = 8;

    // Working width of the slice helper; must cover ACC_W and OUT_W.
    localparam int SLICE_MAX_W = 64;

    typedef struct packed {
        logic [SLICE_MAX_W-1:0] val;
        logic                   sat;
    } slice_t;

    // A single-bunch table still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // v is the already-shifted, sign-extended accumulator value. The flag
    // reports out-of-range independently of whether clamping is enabled.
    function automatic slice_t slice_sat(input logic signed [SLICE_MAX_W-1:0] v,
                                         input int unsigned out_w,
                                         input logic sat_en);
        logic signed [SLICE_MAX_W-1:0] hi;
        logic signed [SLICE_MAX_W-1:0] lo;
        slice_t r;
        hi    = (SLICE_MAX_W'(1) <<< (out_w - 1)) - SLICE_MAX_W'(1);
        lo    = ~hi;
        r.sat = (v > hi) || (v < lo);
        if (sat_en && (v > hi)) begin
            r.val = hi;
        end else if (sat_en && (v < lo)) begin
            r.val = lo;
        end else begin
            r.val = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_fb_corr_table.sv
// Per-bunch correction table: clear when store is low, capture S4 at the
// programmed counter value, and a registered read-out of the current bunch.
module dsp_fb_corr_table
    import dsp_fb_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int N_BUNCH    = N_BUNCH_DEF,
    parameter int IDX_W      = 2,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int CAPTURE_AT = CAPTURE_AT_DEF
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    store_strb,
    input  logic [CNT_W-1:0]        cnt,
    input  logic [IDX_W-1:0]        idx,
    input  logic signed [ACC_W-1:0] s4,
    output logic signed [ACC_W-1:0] corr_q
);

    logic signed [ACC_W-1:0] table_q [N_BUNCH];
    logic signed [ACC_W-1:0] table_d [N_BUNCH];
    logic signed [ACC_W-1:0] corr_d;

    always_comb begin
        for (int i = 0; i < N_BUNCH; i++) begin
            table_d[i] = table_q[i];
        end
        if (!store_strb) begin
            for (int i = 0; i < N_BUNCH; i++) begin
                table_d[i] = '0;
            end
        end else if (cnt == CNT_W'(CAPTURE_AT)) begin
            if (int'(idx) < N_BUNCH) begin
                table_d[idx] = s4;
            end
        end
    end

    // Reads the pre-write contents, so a same-cycle capture is seen one cycle later.
    always_comb begin
        corr_d = '0;
        if (int'(idx) < N_BUNCH) begin
            corr_d = table_q[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BUNCH; i++) begin
                table_q[i] <= '0;
            end
            corr_q <= '0;
        end else begin
            for (int i = 0; i < N_BUNCH; i++) begin
                table_q[i] <= table_d[i];
            end
            corr_q <= corr_d;
        end
    end

endmodule

// File: rtl/dsp_bunch_fb_mac.sv
// Multi-bunch charge x signal feedback MAC: six-register pipeline with a
// windowed per-bunch correction add-back and a saturating output slice.
module dsp_bunch_fb_mac
    import dsp_fb_pkg::*;
#(
    parameter int CHARGE_W   = CHARGE_W_DEF,
    parameter int SIGNAL_W   = SIGNAL_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int OUT_LSB    = OUT_LSB_DEF,
    parameter int N_BUNCH    = N_BUNCH_DEF,
    parameter int WINDOW     = WINDOW_DEF,
    parameter int CAPTURE_AT = CAPTURE_AT_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    localparam int IDX_W     = idx_w(N_BUNCH)
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [CHARGE_W-1:0] charge_in,
    input  logic signed [SIGNAL_W-1:0] signal_in,
    input  logic                       delay_en,
    input  logic                       store_strb,
    input  logic                       bunch_strb,
    input  logic                       train_strb,
    input  logic                       sat_en,
    output logic signed [OUT_W-1:0]    dsp_out,
    output logic                       sat_flag,
    output logic [IDX_W-1:0]           bunch_idx
);

    logic signed [CHARGE_W-1:0] chg_q, chg_d;
    logic signed [SIGNAL_W-1:0] sig_q, sig_d;
    logic signed [ACC_W-1:0]    s1_q, s1_d;
    logic signed [ACC_W-1:0]    s2_q, s2_d;
    logic signed [ACC_W-1:0]    s3_q, s3_d;
    logic signed [ACC_W-1:0]    s4_q, s4_d;
    logic signed [OUT_W-1:0]    dsp_q, dsp_d;
    logic                       sat_q, sat_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       bstrb_q, bstrb_d;

    logic signed [ACC_W-1:0]       corr_q;
    logic                          add;
    logic signed [SLICE_MAX_W-1:0] v_ext;
    slice_t                        sl;

    // Datapath: input regs, product, two delays, add-back, slice.
    always_comb begin
        chg_d = charge_in;
        sig_d = signal_in;
        s1_d  = ACC_W'(chg_q) * ACC_W'(sig_q);
        s2_d  = s1_q;
        s3_d  = s2_q;
        add   = delay_en && (cnt_q < CNT_W'(WINDOW));
        s4_d  = s3_q + (add ? corr_q : '0);
        v_ext = SLICE_MAX_W'(s4_q >>> OUT_LSB);
        sl    = slice_sat(v_ext, OUT_W, sat_en);
        dsp_d = sl.val[OUT_W-1:0];
        sat_d = sl.sat;
    end

    // Counter sticks at all-ones so a long gap never re-opens the window.
    always_comb begin
        bstrb_d = bunch_strb;
        if (bunch_strb) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (train_strb) begin
            idx_d = '0;
        end else if (bunch_strb && !bstrb_q) begin
            idx_d = (idx_q == IDX_W'(N_BUNCH - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q   <= '0;
            sig_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            s4_q    <= '0;
            dsp_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            bstrb_q <= 1'b0;
        end else begin
            chg_q   <= chg_d;
            sig_q   <= sig_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            s4_q    <= s4_d;
            dsp_q   <= dsp_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bstrb_q <= bstrb_d;
        end
    end

    dsp_fb_corr_table #(
        .ACC_W      (ACC_W),
        .N_BUNCH    (N_BUNCH),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W),
        .CAPTURE_AT (CAPTURE_AT)
    ) u_corr_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .store_strb (store_strb),
        .cnt        (cnt_q),
        .idx        (idx_q),
        .s4         (s4_q),
        .corr_q     (corr_q)
    );

    assign dsp_out   = dsp_q;
    assign sat_flag  = sat_q;
    assign bunch_idx = idx_q;

endmodule

// File: tb/tb_dsp_bunch_fb_mac.sv
// Directed plus randomized bench for dsp_bunch_fb_mac against a behavioural
// model of the train/bunch correction rules.
module tb_dsp_bunch_fb_mac;

    localparam int NB   = 4;
    localparam int WIN  = 14;
    localparam int CAP  = 1;
    localparam int CMAX = 255;
    localparam longint OMAX = 4095;
    localparam longint OMIN = -4096;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [20:0] charge_in = '0;
    logic signed [14:0] signal_in = '0;
    logic               delay_en = 1'b0;
    logic               store_strb = 1'b0;
    logic               bunch_strb = 1'b0;
    logic               train_strb = 1'b0;
    logic               sat_en = 1'b0;
    logic signed [12:0] dsp_out;
    logic               sat_flag;
    logic [1:0]         bunch_idx;

    int errors = 0;
    int checks = 0;

    dsp_bunch_fb_mac dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .charge_in  (charge_in),
        .signal_in  (signal_in),
        .delay_en   (delay_en),
        .store_strb (store_strb),
        .bunch_strb (bunch_strb),
        .train_strb (train_strb),
        .sat_en     (sat_en),
        .dsp_out    (dsp_out),
        .sat_flag   (sat_flag),
        .bunch_idx  (bunch_idx)
    );

    always #5 clk = ~clk;

    // Reference model state
    longint m_line[$];
    longint m_s4;
    longint m_out;
    bit     m_sat;
    longint m_tab[NB];
    longint m_corr;
    int     m_cnt;
    int     m_idx;
    bit     m_prev_b;
    int     c_v;
    int     s_v;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint exp_slice(input longint s4, input bit se, output bit flag);
        longint v;
        longint w;
        v    = s4 >>> 12;
        flag = (v > OMAX) || (v < OMIN);
        if (se) begin
            w = (v > OMAX) ? OMAX : ((v < OMIN) ? OMIN : v);
        end else begin
            w = v & 64'd8191;
            if (w >= 4096) w = w - 8192;
        end
        return w;
    endfunction

    task automatic model_reset();
        m_line = {64'sd0, 64'sd0, 64'sd0, 64'sd0};
        m_s4 = 0; m_out = 0; m_sat = 0; m_corr = 0;
        m_cnt = 0; m_idx = 0; m_prev_b = 0;
        for (int i = 0; i < NB; i++) m_tab[i] = 0;
    endtask

    task automatic model_step(input int c, input int s, input bit den, input bit st,
                              input bit bs, input bit ts, input bit se);
        longint s3;
        longint n_s4;
        longint n_out;
        bit     n_sat;
        longint n_corr;
        s3 = m_line.pop_front();
        m_line.push_back(longint'(c) * longint'(s));
        n_s4   = s3 + ((den && (m_cnt < WIN)) ? m_corr : 0);
        n_out  = exp_slice(m_s4, se, n_sat);
        n_corr = m_tab[m_idx];
        if (!st) begin
            for (int i = 0; i < NB; i++) m_tab[i] = 0;
        end else if (m_cnt == CAP) begin
            m_tab[m_idx] = m_s4;
        end
        if (ts) m_idx = 0;
        else if (bs && !m_prev_b) m_idx = (m_idx + 1) % NB;
        m_cnt    = bs ? 0 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
        m_prev_b = bs;
        m_s4     = n_s4;
        m_out    = n_out;
        m_sat    = n_sat;
        m_corr   = n_corr;
    endtask

    task automatic drive(input int c, input int s);
        c_v = c;
        s_v = s;
        charge_in = c[20:0];
        signal_in = s[14:0];
    endtask

    task automatic tick(input string tag);
        int c;
        int s;
        bit den, st, bs, ts, se;
        c = c_v; s = s_v; den = delay_en; st = store_strb;
        bs = bunch_strb; ts = train_strb; se = sat_en;
        @(posedge clk);
        model_step(c, s, den, st, bs, ts, se);
        #1;
        chk({tag, "_out"}, 64'(dsp_out), m_out);
        chk({tag, "_sat"}, 64'(sat_flag), 64'(m_sat));
        chk({tag, "_idx"}, 64'(bunch_idx), 64'(m_idx));
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out", 64'(dsp_out), 0);
        chk("rst_sat", 64'(sat_flag), 0);
        chk("rst_idx", 64'(bunch_idx), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One bunch: strobe high for hi cycles, then low for lo cycles.
    task automatic bunch(input string tag, input int hi, input int lo, input bit with_train);
        bunch_strb = 1'b1;
        train_strb = with_train;
        ticks(tag, hi);
        bunch_strb = 1'b0;
        train_strb = 1'b0;
        ticks(tag, lo);
    endtask

    int rc;
    int rs;
    bit found;

    initial begin
        model_reset();
        drive(0, 0);
        do_reset();

        // Basic latency and product scaling
        drive(1000, 100);
        ticks("lat", 5);
        chk("lat5_zero", 64'(dsp_out), 0);
        tick("lat");
        chk("lat6_24", 64'(dsp_out), 24);
        chk("lat6_nosat", 64'(sat_flag), 0);

        // Saturation and wrap of a full-scale product
        drive(1048575, 16383);
        sat_en = 1'b1;
        ticks("sat", 7);
        chk("sat_clamp", 64'(dsp_out), 4095);
        chk("sat_flag1", 64'(sat_flag), 1);
        sat_en = 1'b0;
        tick("wrap");
        chk("wrap_val", 64'(dsp_out), -260);
        chk("wrap_flag", 64'(sat_flag), 1);

        // Store and apply on a single bunch slot held at index 0
        drive(1000, 100);
        store_strb = 1'b0;
        ticks("flush", 8);
        store_strb = 1'b1;
        bunch("cap", 3, 20, 1'b1);
        delay_en = 1'b1;
        bunch_strb = 1'b1;
        train_strb = 1'b1;
        ticks("apply", 3);
        bunch_strb = 1'b0;
        train_strb = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick("apply");
            if (dsp_out == 13'sd48) found = 1'b1;
        end
        chk("apply_48_seen", 64'(found), 1);
        ticks("apply", 30);
        chk("after_win_24", 64'(dsp_out), 24);

        // Multi-bunch trains with random products per bunch
        for (int t = 0; t < 3; t++) begin
            for (int b = 0; b < NB; b++) begin
                rc = int'($urandom_range(0, 1 << 20)) - (1 << 19);
                rs = int'($urandom_range(0, 1 << 14)) - (1 << 13);
                drive(rc, rs);
                delay_en = (t > 0);
                bunch("mb", 2, 18, (t == 0) && (b == 0));
            end
        end
        bunch("wrap_idx", 2, 3, 1'b0);
        bunch("coinc", 2, 3, 1'b1);
        chk("coinc_idx0", 64'(bunch_idx), 0);

        // Clear via store low, then a train to show no add-back
        store_strb = 1'b0;
        tick("clr");
        store_strb = 1'b1;
        for (int b = 0; b < NB; b++) bunch("postclr", 2, 16, b == 0);

        // Reset in the middle of a window
        bunch_strb = 1'b1;
        ticks("mid", 2);
        bunch_strb = 1'b0;
        ticks("mid", 5);
        do_reset();
        ticks("postrst", 10);
        for (int b = 0; b < NB; b++) bunch("postrst_b", 2, 16, b == 0);

        // Long gap: counter must stick and the window stay shut
        drive(200000, 3000);
        delay_en = 1'b1;
        bunch("longcap", 2, 12, 1'b1);
        bunch("long", 2, 300, 1'b1);

        // Fully random control and data
        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20),
                  int'($urandom_range(0, (1 << 15) - 1)) - (1 << 14));
            delay_en   = ($urandom_range(0, 3) != 0);
            store_strb = ($urandom_range(0, 15) != 0);
            bunch_strb = ($urandom_range(0, 7) == 0);
            train_strb = ($urandom_range(0, 31) == 0);
            sat_en     = $urandom_range(0, 1);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
